// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared types and helpers for the 8-way time-interleaved ADC capture buffer.
//   ADC_WAYS / ADC_BITS : frame geometry (ways per frame, bits per sample)
//   sample_t            : one corrected sample, signed two's complement
//   frame_t             : one frame, way 0 in the least significant slot
//   cap_state_t         : capture sequencer states
//   sat_sub()           : BITS-wide signed subtract with clamp and sat flag
// -----------------------------------------------------------------------------
package adc_capture_pkg;

  localparam int ADC_WAYS  = 8;
  localparam int ADC_BITS  = 9;
  localparam int ADC_DEPTH = 64;
  localparam int ADC_AW    = 6;

  typedef logic signed [ADC_BITS-1:0] sample_t;

  // Packed so a frame maps directly onto the flat bus: way k at [k*BITS +: BITS].
  typedef sample_t [ADC_WAYS-1:0] frame_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SKIPPING,
    CAPTURE,
    READOUT
  } cap_state_t;

  typedef struct packed {
    logic    sat;
    sample_t val;
  } sat_res_t;

  // a - b in ADC_BITS+1 bits, clamped back into the ADC_BITS signed range.
  // The extra bit disagreeing with the sample MSB means the result overflowed;
  // the extra bit then carries the true sign and selects the clamp rail.
  function automatic sat_res_t sat_sub(input sample_t a, input sample_t b);
    logic [ADC_BITS:0] r;
    sat_res_t          res;
    r       = {a[ADC_BITS-1], a} - {b[ADC_BITS-1], b};
    res.sat = r[ADC_BITS] ^ r[ADC_BITS-1];
    if (!res.sat) begin
      res.val = r[ADC_BITS-1:0];
    end else if (r[ADC_BITS]) begin
      res.val = {1'b1, {(ADC_BITS-1){1'b0}}};
    end else begin
      res.val = {1'b0, {(ADC_BITS-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_offset_corr.sv
// -----------------------------------------------------------------------------
// adc_offset_corr
// Correction for one interleave way: offset-binary to two's complement,
// subtract the per-way offset, clamp, register. One cycle of latency.
//   clk_i     : ADC core clock
//   rst_i     : synchronous active-high reset
//   code_i    : raw offset-binary ADC code
//   offset_i  : signed per-way correction
//   data_o    : registered corrected sample (two's complement)
//   sat_o     : registered flag, high when data_o was clamped
// -----------------------------------------------------------------------------
module adc_offset_corr
  import adc_capture_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADC_BITS-1:0] code_i,
  input  logic [ADC_BITS-1:0] offset_i,
  output logic [ADC_BITS-1:0] data_o,
  output logic                sat_o
);

  sample_t  s_code;
  sat_res_t res_d;
  sample_t  data_q;
  logic     sat_q;

  always_comb begin
    // Flipping the MSB of an offset-binary code yields its two's complement value.
    s_code = {~code_i[ADC_BITS-1], code_i[ADC_BITS-2:0]};
    res_d  = sat_sub(s_code, offset_i);
  end

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      data_q <= res_d.val;
      sat_q  <= res_d.sat;
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// -----------------------------------------------------------------------------
// adc_capture_buffer
// Receive end of the 8-way time-interleaved SAR ADC bus. Corrects every frame,
// and on an armed trigger snapshots NFRAMES frames into a local buffer, then
// streams them out over valid/ready.
//   ADCCLK, CLKRST      : ADC core clock, synchronous active-high reset
//   ADCDATA, OFFSET     : raw offset-binary frame, per-way signed offsets
//   ARM, ABORT          : start a capture from IDLE / return to IDLE
//   TRIGSEL, TRIG       : immediate trigger or wait for TRIG level
//   SKIP, NFRAMES       : frames discarded after trigger, frames captured (0=DEPTH)
//   OUT_VALID/READY/DATA/LAST : output frame stream
//   BUSY, DONE, SATCNT  : status; DONE is sticky, SATCNT counts saturated frames
// The correction arithmetic is sized by the package, so BITS must equal ADC_BITS.
// -----------------------------------------------------------------------------
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int WAYS  = ADC_WAYS,
  parameter int BITS  = ADC_BITS,
  parameter int DEPTH = ADC_DEPTH,
  parameter int AW    = ADC_AW
) (
  input  logic                 ADCCLK,
  input  logic                 CLKRST,
  input  logic [WAYS*BITS-1:0] ADCDATA,
  input  logic [WAYS*BITS-1:0] OFFSET,
  input  logic                 ARM,
  input  logic                 ABORT,
  input  logic                 TRIGSEL,
  input  logic                 TRIG,
  input  logic [7:0]           SKIP,
  input  logic [AW-1:0]        NFRAMES,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WAYS*BITS-1:0] OUT_DATA,
  output logic                 OUT_LAST,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [15:0]          SATCNT
);

  // ---------------------------------------------------------------------------
  // Correction stage: one registered corrector per way
  // ---------------------------------------------------------------------------
  logic [WAYS*BITS-1:0] corr_frame;
  logic [WAYS-1:0]      sat_way;
  logic                 frame_sat;

  for (genvar k = 0; k < WAYS; k++) begin : g_way
    adc_offset_corr u_corr (
      .clk_i    (ADCCLK),
      .rst_i    (CLKRST),
      .code_i   (ADCDATA[k*BITS +: BITS]),
      .offset_i (OFFSET[k*BITS +: BITS]),
      .data_o   (corr_frame[k*BITS +: BITS]),
      .sat_o    (sat_way[k])
    );
  end

  assign frame_sat = |sat_way;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  cap_state_t state_q, state_d;

  logic [7:0]           skip_q;   // latched SKIP
  logic [AW:0]          n_q;      // latched frame count, 1..DEPTH
  logic [7:0]           scnt_q;   // cycles spent in SKIPPING
  logic [AW:0]          wcnt_q;   // frames written
  logic [AW:0]          rcnt_q;   // frames loaded into the output register
  logic                 prime_q;  // first CAPTURE cycle: corrector still holds the trigger-edge frame
  logic                 valid_q;
  logic                 last_q;
  logic [WAYS*BITS-1:0] data_q;
  logic                 done_q;
  logic [15:0]          satcnt_q;

  logic [WAYS*BITS-1:0] mem_q [DEPTH];
  logic [WAYS*BITS-1:0] mem_rd;

  // Decoded controls
  logic trigger;
  logic arm_go;
  logic wr_en;
  logic last_wr;
  logic rd_load;
  logic hs;

  assign trigger = ~TRIGSEL | TRIG;
  assign last_wr = (wcnt_q == n_q - 1'b1);
  assign hs      = valid_q & OUT_READY;
  assign mem_rd  = mem_q[rcnt_q[AW-1:0]];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ADCCLK) begin
    if (CLKRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (ABORT overrides everything, including ARM)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (ARM) state_d = ARMED;
        ARMED:    if (trigger) state_d = (skip_q != 8'd0) ? SKIPPING : CAPTURE;
        SKIPPING: if (scnt_q == skip_q - 8'd1) state_d = CAPTURE;
        CAPTURE:  if (wr_en && last_wr) state_d = READOUT;
        READOUT:  if (hs && last_q) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    BUSY    = (state_q != IDLE);
    arm_go  = (state_q == IDLE) & ARM & ~ABORT;
    wr_en   = (state_q == CAPTURE) & ~prime_q;
    // Refill the output register whenever it is empty or being consumed.
    rd_load = (state_q == READOUT) & (~valid_q | OUT_READY) & (rcnt_q != n_q);
  end

  // ---------------------------------------------------------------------------
  // Counters, status and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ADCCLK) begin
    if (CLKRST) begin
      skip_q   <= '0;
      n_q      <= '0;
      scnt_q   <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      prime_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      satcnt_q <= '0;
    end else begin
      // Entering CAPTURE after edge t+SKIP, the corrector still holds that
      // edge's frame; the first frame to keep is the one sampled one edge later.
      prime_q <= (state_d == CAPTURE) && (state_q != CAPTURE);

      if (ABORT) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        if (arm_go) begin
          done_q   <= 1'b0;
          satcnt_q <= '0;
          skip_q   <= SKIP;
          n_q      <= (NFRAMES == '0) ? (AW+1)'(DEPTH) : {1'b0, NFRAMES};
          scnt_q   <= '0;
          wcnt_q   <= '0;
          rcnt_q   <= '0;
        end

        if (state_q == SKIPPING) begin
          scnt_q <= scnt_q + 8'd1;
        end

        if (wr_en) begin
          wcnt_q <= wcnt_q + 1'b1;
          if (frame_sat && (satcnt_q != 16'hFFFF)) begin
            satcnt_q <= satcnt_q + 16'd1;
          end
        end

        if (rd_load) begin
          valid_q <= 1'b1;
          data_q  <= mem_rd;
          last_q  <= (rcnt_q == n_q - 1'b1);
          rcnt_q  <= rcnt_q + 1'b1;
        end else if (hs) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end

        if (hs && last_q) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture storage: one write port, one read port
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; its contents are only read after being
  // written in the same capture, and leaving it unreset keeps it a plain array.
  always_ff @(posedge ADCCLK) begin
    if (wr_en) begin
      mem_q[wcnt_q[AW-1:0]] <= corr_frame;
    end
  end

  assign OUT_VALID = valid_q;
  assign OUT_DATA  = data_q;
  assign OUT_LAST  = last_q;
  assign DONE      = done_q;
  assign SATCNT    = satcnt_q;

endmodule
